// File: rtl/sram_like_arbiter_if.sv
// SRAM-like master bus: a request channel (req/addr_ok) and a completion channel (data_ok/rdata).
interface sram_like_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m_req;
  logic              m_wr;
  logic [1:0]        m_size;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_addr_ok;
  logic              m_data_ok;
  logic [DATA_W-1:0] m_rdata;

  modport master (
    output m_req, m_wr, m_size, m_addr, m_wdata,
    input  m_addr_ok, m_data_ok, m_rdata
  );

  modport slave (
    input  m_req, m_wr, m_size, m_addr, m_wdata,
    output m_addr_ok, m_data_ok, m_rdata
  );
endinterface

// File: rtl/sram_like_arbiter.sv
// Shares one single-outstanding SRAM-like bus between fetch and data ports; data goes first.
// Results are held until the pipeline advances, and stall_by_sram covers unfinished work.
module sram_like_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inst_en,
  input  logic [ADDR_W-1:0]    inst_addr,
  output logic [DATA_W-1:0]    inst_rdata,
  input  logic                 data_en,
  input  logic [3:0]           data_wen,
  input  logic [1:0]           data_size,
  input  logic [ADDR_W-1:0]    data_addr,
  input  logic [DATA_W-1:0]    data_wdata,
  output logic [DATA_W-1:0]    data_rdata,
  input  logic                 pipe_stall,
  output logic                 stall_by_sram,
  sram_like_arbiter_if.master  m_bus
);
  typedef enum logic [2:0] {IDLE, D_REQ, D_WAIT, I_REQ, I_WAIT} state_t;

  state_t            state_q, state_d;
  logic              inst_done_q, inst_done_d;
  logic              data_done_q, data_done_d;
  logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
  logic              need_d, need_i, advance;

  assign need_d        = data_en & ~data_done_q;
  assign need_i        = inst_en & ~inst_done_q;
  assign stall_by_sram = need_d | need_i;
  assign advance       = ~stall_by_sram & ~pipe_stall;
  assign inst_rdata    = inst_rdata_q;
  assign data_rdata    = data_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      inst_done_q  <= 1'b0;
      data_done_q  <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      inst_done_q  <= inst_done_d;
      data_done_q  <= data_done_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    inst_done_d     = inst_done_q;
    data_done_d     = data_done_q;
    inst_rdata_d    = inst_rdata_q;
    data_rdata_d    = data_rdata_q;
    m_bus.m_req     = 1'b0;
    m_bus.m_wr      = 1'b0;
    m_bus.m_size    = 2'd0;
    m_bus.m_addr    = '0;
    m_bus.m_wdata   = '0;

    case (state_q)
      IDLE: begin
        if (need_d) begin
          state_d = D_REQ;
        end else if (need_i) begin
          state_d = I_REQ;
        end
      end
      D_REQ: begin
        m_bus.m_req   = 1'b1;
        m_bus.m_wr    = |data_wen;
        m_bus.m_size  = data_size;
        m_bus.m_addr  = data_addr;
        m_bus.m_wdata = data_wdata;
        if (m_bus.m_addr_ok) begin
          state_d = D_WAIT;
        end
      end
      D_WAIT: begin
        // Stores also capture m_rdata; the value is simply never consumed.
        if (m_bus.m_data_ok) begin
          data_rdata_d = m_bus.m_rdata;
          data_done_d  = 1'b1;
          state_d      = need_i ? I_REQ : IDLE;
        end
      end
      I_REQ: begin
        m_bus.m_req  = 1'b1;
        m_bus.m_size = 2'd2;
        m_bus.m_addr = inst_addr;
        if (m_bus.m_addr_ok) begin
          state_d = I_WAIT;
        end
      end
      I_WAIT: begin
        if (m_bus.m_data_ok) begin
          inst_rdata_d = m_bus.m_rdata;
          inst_done_d  = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Completion and advance never coincide: stall is high while a transfer is open.
    if (advance) begin
      inst_done_d = 1'b0;
      data_done_d = 1'b0;
    end
  end
endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: bus slave, transaction-level reference model
// checked every cycle, and hand-computed literal expectations per scenario.
module tb_sram_like_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        inst_en;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        data_en;
  logic [3:0]  data_wen;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        pipe_stall;
  logic        stall_by_sram;

  int total = 0;
  int bad   = 0;

  int          addr_wait = 0;
  int          xfer_cnt  = 0;
  logic        stray     = 1'b0;

  sram_like_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  sram_like_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .inst_en       (inst_en),
    .inst_addr     (inst_addr),
    .inst_rdata    (inst_rdata),
    .data_en       (data_en),
    .data_wen      (data_wen),
    .data_size     (data_size),
    .data_addr     (data_addr),
    .data_wdata    (data_wdata),
    .data_rdata    (data_rdata),
    .pipe_stall    (pipe_stall),
    .stall_by_sram (stall_by_sram),
    .m_bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] resp_of(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h3C08_BFAF;
    if (a == 32'h8000_1000) return 32'h1234_5678;
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // Bus slave: addr_ok after addr_wait request cycles, data_ok exactly one cycle later.
  initial begin
    logic        s_pend;
    logic [31:0] s_addr;
    int          aw_cnt;
    s_pend = 1'b0;
    s_addr = '0;
    aw_cnt = 0;
    bus.m_addr_ok = 1'b0;
    bus.m_data_ok = 1'b0;
    bus.m_rdata   = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.m_addr_ok = 1'b0;
      bus.m_data_ok = 1'b0;
      if (rst) begin
        s_pend = 1'b0;
        aw_cnt = 0;
      end else if (s_pend) begin
        bus.m_data_ok = 1'b1;
        bus.m_rdata   = resp_of(s_addr);
        s_pend        = 1'b0;
      end else if (stray) begin
        bus.m_addr_ok = 1'b1;
        bus.m_data_ok = 1'b1;
        bus.m_rdata   = 32'hFFFF_FFFF;
      end else if (bus.m_req) begin
        if (aw_cnt >= addr_wait) begin
          bus.m_addr_ok = 1'b1;
          s_pend        = 1'b1;
          s_addr        = bus.m_addr;
          aw_cnt        = 0;
          xfer_cnt++;
        end else begin
          aw_cnt++;
        end
      end
    end
  end

  // Reference model: per pipeline cycle, each enabled port is served once, data first.
  logic        mdl_served_d = 1'b0;
  logic        mdl_served_i = 1'b0;
  logic        mdl_open     = 1'b0;
  logic        mdl_open_d   = 1'b0;
  logic [31:0] mdl_inst_q   = '0;
  logic [31:0] mdl_data_q   = '0;

  always @(negedge clk) begin
    logic want_d, want_i, busy;
    want_d = data_en && !mdl_served_d;
    want_i = inst_en && !mdl_served_i;
    busy   = want_d || want_i;
    if (!rst) begin
      chk("model_stall", {31'd0, stall_by_sram}, {31'd0, busy});
      chk("model_inst_rdata", inst_rdata, mdl_inst_q);
      chk("model_data_rdata", data_rdata, mdl_data_q);
      if (!busy || mdl_open) begin
        chk("model_req_quiet", {31'd0, bus.m_req}, 32'd0);
      end else if (bus.m_req) begin
        if (want_d) begin
          chk("model_d_wr",    {31'd0, bus.m_wr}, {31'd0, (data_wen != 4'd0)});
          chk("model_d_size",  {30'd0, bus.m_size}, {30'd0, data_size});
          chk("model_d_addr",  bus.m_addr, data_addr);
          chk("model_d_wdata", bus.m_wdata, data_wdata);
        end else begin
          chk("model_i_wr",    {31'd0, bus.m_wr}, 32'd0);
          chk("model_i_size",  {30'd0, bus.m_size}, 32'd2);
          chk("model_i_addr",  bus.m_addr, inst_addr);
          chk("model_i_wdata", bus.m_wdata, 32'd0);
        end
      end
    end
    if (rst) begin
      mdl_served_d = 1'b0;
      mdl_served_i = 1'b0;
      mdl_open     = 1'b0;
      mdl_inst_q   = '0;
      mdl_data_q   = '0;
    end else if (!busy && !pipe_stall) begin
      mdl_served_d = 1'b0;
      mdl_served_i = 1'b0;
    end else begin
      if (bus.m_data_ok && mdl_open) begin
        if (mdl_open_d) begin
          mdl_served_d = 1'b1;
          mdl_data_q   = bus.m_rdata;
        end else begin
          mdl_served_i = 1'b1;
          mdl_inst_q   = bus.m_rdata;
        end
        mdl_open = 1'b0;
      end
      if (bus.m_req && bus.m_addr_ok) begin
        mdl_open   = 1'b1;
        mdl_open_d = want_d;
      end
    end
  end

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (stall_by_sram && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_timeout"}, {31'd0, stall_by_sram}, 32'd0);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    inst_en    = 1'b0;
    data_en    = 1'b0;
    data_wen   = 4'd0;
    pipe_stall = 1'b0;
  endtask

  initial begin
    int x0;
    rst = 1'b1; inst_en = 1'b0; inst_addr = '0; data_en = 1'b0; data_wen = 4'd0;
    data_size = 2'd0; data_addr = '0; data_wdata = '0; pipe_stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_req", {31'd0, bus.m_req}, 32'd0);
    chk("reset_stall", {31'd0, stall_by_sram}, 32'd0);
    chk("reset_inst_rdata", inst_rdata, 32'd0);
    chk("reset_data_rdata", data_rdata, 32'd0);

    // Fetch only, zero-wait slave.
    @(posedge clk); #1;
    inst_en = 1'b1; inst_addr = 32'hBFC0_0000;
    @(negedge clk);
    chk("f_c0_stall", {31'd0, stall_by_sram}, 32'd1);
    chk("f_c0_req", {31'd0, bus.m_req}, 32'd0);
    @(negedge clk);
    chk("f_c1_req", {31'd0, bus.m_req}, 32'd1);
    chk("f_c1_addr", bus.m_addr, 32'hBFC0_0000);
    chk("f_c1_wr", {31'd0, bus.m_wr}, 32'd0);
    chk("f_c1_size", {30'd0, bus.m_size}, 32'd2);
    @(negedge clk);
    chk("f_c2_stall", {31'd0, stall_by_sram}, 32'd1);
    @(negedge clk);
    chk("f_c3_stall", {31'd0, stall_by_sram}, 32'd0);
    chk("f_c3_rdata", inst_rdata, 32'h3C08_BFAF);
    advance();

    // Simultaneous load and fetch: data first.
    inst_en = 1'b1; inst_addr = 32'hBFC0_0004;
    data_en = 1'b1; data_wen = 4'd0; data_size = 2'd2; data_addr = 32'h8000_1000; data_wdata = '0;
    @(negedge clk);
    chk("both_c0_stall", {31'd0, stall_by_sram}, 32'd1);
    @(negedge clk);
    chk("both_c1_addr", bus.m_addr, 32'h8000_1000);
    chk("both_c1_req", {31'd0, bus.m_req}, 32'd1);
    @(negedge clk);
    chk("both_c2_req", {31'd0, bus.m_req}, 32'd0);
    @(negedge clk);
    chk("both_c3_addr", bus.m_addr, 32'hBFC0_0004);
    chk("both_c3_req", {31'd0, bus.m_req}, 32'd1);
    @(negedge clk);
    chk("both_c4_stall", {31'd0, stall_by_sram}, 32'd1);
    @(negedge clk);
    chk("both_c5_stall", {31'd0, stall_by_sram}, 32'd0);
    chk("both_c5_drdata", data_rdata, 32'h1234_5678);
    chk("both_c5_irdata", inst_rdata, 32'hE59A_0F0B);
    advance();

    // Byte store.
    data_en = 1'b1; data_wen = 4'b0100; data_size = 2'd0;
    data_addr = 32'h8000_0002; data_wdata = 32'h00AB_0000;
    @(negedge clk);
    @(negedge clk);
    chk("st_wr", {31'd0, bus.m_wr}, 32'd1);
    chk("st_size", {30'd0, bus.m_size}, 32'd0);
    chk("st_addr", bus.m_addr, 32'h8000_0002);
    chk("st_wdata", bus.m_wdata, 32'h00AB_0000);
    wait_done("st");
    advance();

    // Back-pressure: addr_ok low for 5 request cycles.
    addr_wait = 5;
    x0 = xfer_cnt;
    inst_en = 1'b1; inst_addr = 32'hBFC0_0100;
    @(negedge clk);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk($sformatf("bp_c%0d_req", i), {31'd0, bus.m_req}, 32'd1);
      chk($sformatf("bp_c%0d_addr", i), bus.m_addr, 32'hBFC0_0100);
    end
    wait_done("bp");
    chk("bp_xfers", xfer_cnt - x0, 32'd1);
    addr_wait = 0;
    advance();

    // Pipeline held by a divider after the fetch completes.
    pipe_stall = 1'b1;
    inst_en = 1'b1; inst_addr = 32'hBFC0_0200;
    x0 = xfer_cnt;
    wait_done("ps");
    chk("ps_rdata", inst_rdata, 32'hE59A_0D0F);
    for (int i = 4; i <= 6; i++) begin
      @(negedge clk);
      chk($sformatf("ps_c%0d_req", i), {31'd0, bus.m_req}, 32'd0);
      chk($sformatf("ps_c%0d_rdata", i), inst_rdata, 32'hE59A_0D0F);
    end
    @(posedge clk); #1;
    pipe_stall = 1'b0;
    @(negedge clk);
    chk("ps_c7_stall", {31'd0, stall_by_sram}, 32'd0);
    @(posedge clk); #1;
    inst_addr = 32'hBFC0_0204;
    @(negedge clk);
    chk("ps_c8_stall", {31'd0, stall_by_sram}, 32'd1);
    chk("ps_hold_xfers", xfer_cnt - x0, 32'd1);
    @(negedge clk);
    chk("ps_c9_req", {31'd0, bus.m_req}, 32'd1);
    chk("ps_c9_addr", bus.m_addr, 32'hBFC0_0204);
    wait_done("ps2");
    advance();

    // Stray handshakes while idle are ignored.
    x0 = xfer_cnt;
    @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    @(negedge clk);
    chk("stray_irdata", inst_rdata, 32'hE59A_0D0B);
    chk("stray_drdata", data_rdata, 32'hDA5A_0F0D);
    chk("stray_req", {31'd0, bus.m_req}, 32'd0);
    chk("stray_xfers", xfer_cnt - x0, 32'd0);

    // Reset while in D_WAIT.
    @(posedge clk); #1;
    data_en = 1'b1; data_wen = 4'd0; data_size = 2'd2; data_addr = 32'h8000_2000;
    @(negedge clk);
    @(negedge clk);
    chk("rst_c1_req", {31'd0, bus.m_req}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; data_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req", {31'd0, bus.m_req}, 32'd0);
    chk("rst_stall", {31'd0, stall_by_sram}, 32'd0);
    chk("rst_irdata", inst_rdata, 32'd0);
    chk("rst_drdata", data_rdata, 32'd0);
    @(posedge clk); #1;
    data_en = 1'b1; data_addr = 32'h8000_1000;
    @(negedge clk);
    chk("rst_new_stall", {31'd0, stall_by_sram}, 32'd1);
    wait_done("rst_new");
    chk("rst_new_drdata", data_rdata, 32'h1234_5678);
    advance();
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
